// File: rtl/fetch_unit_if.sv
// fetch_unit_if: instruction-memory request/response bus between fetch stage and memory
interface fetch_unit_if;
    logic [31:0] imem_addr;
    logic        imem_req;
    logic [31:0] imem_rdata;
    logic        imem_valid;
    modport master (output imem_addr, imem_req, input imem_rdata, imem_valid);
    modport slave (input imem_addr, imem_req, output imem_rdata, imem_valid);
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: PC/IR owner, next-PC select, variable-latency fetch; FETCH_RETIRE_CNT_EN adds retire_cnt
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [5:0]  HALT_OP  = 6'b111111
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                pc_wre,
    input  logic                ir_wre,
    input  logic [1:0]          pc_src,
    input  logic                ext_sel,
    input  logic [31:0]         rs_data,
    fetch_unit_if.master        imem,
    output logic [31:0]         pc,
    output logic [31:0]         pc_plus4,
    output logic [5:0]          op,
    output logic [4:0]          rs,
    output logic [4:0]          rt,
    output logic [4:0]          rd,
    output logic [4:0]          sa,
    output logic [31:0]         ext_imm,
    output logic                ir_valid,
    output logic                halted
`ifdef FETCH_RETIRE_CNT_EN
    ,
    output logic [31:0]         retire_cnt
`endif
);
    typedef enum logic [1:0] {FETCH, READY, HALTED} state_t;
    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d, ir_q, ir_d, next_pc;
    logic        fetched, advance;
    always_comb begin
        pc       = pc_q;
        pc_plus4 = pc_q + 32'd4;
        op       = ir_q[31:26];
        rs       = ir_q[25:21];
        rt       = ir_q[20:16];
        rd       = ir_q[15:11];
        sa       = ir_q[10:6];
        ext_imm  = {ext_sel ? {16{ir_q[15]}} : 16'h0000, ir_q[15:0]};
        next_pc  = pc_src == 2'b00 ? pc_plus4 :
                   pc_src == 2'b01 ? pc_plus4 + {ext_imm[29:0], 2'b00} :
                   pc_src == 2'b10 ? rs_data : {pc_plus4[31:28], ir_q[25:0], 2'b00};
        fetched  = state_q == FETCH && imem.imem_valid;
        advance  = state_q == READY && op != HALT_OP && pc_wre;
        ir_d     = fetched && ir_wre ? imem.imem_rdata : ir_q;
        pc_d     = advance ? {next_pc[31:2], 2'b00} : pc_q;
        state_d  = fetched ? READY :
                   state_q == READY && op == HALT_OP ? HALTED :
                   advance ? FETCH : state_q;
        // reset forces a visible request at RESET_PC even before the state register settles
        imem.imem_req  = rst || state_q == FETCH;
        imem.imem_addr = rst ? RESET_PC : pc_q;
        ir_valid = !rst && state_q != FETCH;
        halted   = !rst && state_q == HALTED;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FETCH;
            pc_q    <= RESET_PC;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
        end
    end
`ifdef FETCH_RETIRE_CNT_EN
    logic [31:0] cnt_q, cnt_d;
    always_comb begin
        cnt_d      = advance ? cnt_q + 32'd1 : cnt_q;
        retire_cnt = cnt_q;
    end
    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: randomized scoreboard bench for fetch_unit against a behavioural PC/IR model
module tb_fetch_unit;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [5:0]  HALT_OP  = 6'b111111;
    logic        clk = 0, rst = 1, pc_wre = 0, ir_wre = 0, ext_sel = 0;
    logic [1:0]  pc_src = 0;
    logic [31:0] rs_data = 0;
    logic [31:0] pc, pc_plus4, ext_imm;
    logic [5:0]  op;
    logic [4:0]  rs, rt, rd, sa;
    logic        ir_valid, halted;
`ifdef FETCH_RETIRE_CNT_EN
    logic [31:0] retire_cnt;
`endif
    fetch_unit_if bus();
    fetch_unit #(.RESET_PC(RESET_PC), .HALT_OP(HALT_OP)) dut (
        .clk(clk), .rst(rst), .pc_wre(pc_wre), .ir_wre(ir_wre), .pc_src(pc_src),
        .ext_sel(ext_sel), .rs_data(rs_data), .imem(bus), .pc(pc), .pc_plus4(pc_plus4),
        .op(op), .rs(rs), .rt(rt), .rd(rd), .sa(sa), .ext_imm(ext_imm),
        .ir_valid(ir_valid), .halted(halted)
`ifdef FETCH_RETIRE_CNT_EN
        , .retire_cnt(retire_cnt)
`endif
    );
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] ir;
        logic [31:0] imm;
        logic [31:0] pc;
    } exp_t;
    exp_t        exp_q[$];
    logic [31:0] addr_q[$];
    int          checks = 0, errors = 0;
    logic [31:0] m_pc = 0, m_ir = 0, m_cnt = 0;
    logic        m_sel = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ext(input logic [31:0] ir, input logic s);
        logic [31:0] v;
        v = ir & 32'h0000_FFFF;
        if (s && v >= 32'h8000) v = v - 32'h0001_0000;
        return v;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1;
        bus.imem_valid = 0;
        pc_wre = 0;
        tick;
        tick;
        m_pc = RESET_PC;
        m_ir = 0;
        m_cnt = 0;
        addr_q.push_back(RESET_PC);
        rst = 0;
    endtask

    task automatic do_fetch(input logic [31:0] instr, input int waits, input logic irw, input logic sel);
        for (int i = 0; i < waits; i++) begin
            bus.imem_valid = 0;
            pc_wre = 1'($urandom_range(0, 1));
            ir_wre = 1'($urandom_range(0, 1));
            ext_sel = 1'($urandom_range(0, 1));
            tick;
        end
        bus.imem_valid = 1;
        bus.imem_rdata = instr;
        ir_wre = irw;
        pc_wre = 1'($urandom_range(0, 1));
        ext_sel = sel;
        if (irw) m_ir = instr;
        m_sel = sel;
        exp_q.push_back('{m_ir, ext(m_ir, sel), m_pc});
        tick;
        bus.imem_valid = 0;
        bus.imem_rdata = $urandom;
        pc_wre = 0;
    endtask

    task automatic do_adv(input logic [1:0] src, input logic [31:0] rsd, input int idle);
        logic [31:0] np;
        for (int i = 0; i < idle; i++) begin
            bus.imem_valid = 1'($urandom_range(0, 1));
            bus.imem_rdata = $urandom;
            ir_wre = 1'($urandom_range(0, 1));
            tick;
        end
        bus.imem_valid = 0;
        chk("ready_op", 32'(op), m_ir >> 26);
        chk("ready_imm", ext_imm, ext(m_ir, m_sel));
        chk("ready_pc", pc, m_pc);
        case (src)
            2'd0: np = m_pc + 4;
            2'd1: np = m_pc + 4 + ext(m_ir, m_sel) * 4;
            2'd2: np = rsd;
            default: np = ((m_pc + 4) & 32'hF000_0000) | ((m_ir & 32'h03FF_FFFF) << 2);
        endcase
        m_pc = np & ~32'h3;
        m_cnt = m_cnt + 1;
        addr_q.push_back(m_pc);
        pc_src = src;
        rs_data = rsd;
        pc_wre = 1;
        tick;
        pc_wre = 0;
        chk("adv_pc", pc, m_pc);
`ifdef FETCH_RETIRE_CNT_EN
        chk("retire_cnt", retire_cnt, m_cnt);
`endif
    endtask

    logic        prev_req = 0, prev_iv = 0;
    logic [31:0] cur_addr = 0;
    exp_t        e;
    always @(negedge clk) begin
        if (rst) begin
            chk("rst_req", 32'(bus.imem_req), 1);
            chk("rst_addr", bus.imem_addr, RESET_PC);
            chk("rst_ir_valid", 32'(ir_valid), 0);
            chk("rst_halted", 32'(halted), 0);
            prev_req = 0;
            prev_iv = 0;
        end else begin
            if (bus.imem_req && !prev_req) begin
                if (addr_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_fetch addr %h expected no request", bus.imem_addr);
                end else begin
                    cur_addr = addr_q.pop_front();
                    chk("fetch_addr", bus.imem_addr, cur_addr);
                end
            end else if (bus.imem_req) begin
                chk("addr_hold", bus.imem_addr, cur_addr);
            end
            if (ir_valid && !prev_iv) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_ir_valid op %h expected no instruction", op);
                end else begin
                    e = exp_q.pop_front();
                    chk("op", 32'(op), e.ir >> 26);
                    chk("rs", 32'(rs), (e.ir >> 21) & 31);
                    chk("rt", 32'(rt), (e.ir >> 16) & 31);
                    chk("rd", 32'(rd), (e.ir >> 11) & 31);
                    chk("sa", 32'(sa), (e.ir >> 6) & 31);
                    chk("ext_imm", ext_imm, e.imm);
                    chk("ir_pc", pc, e.pc);
                    chk("pc_plus4", pc_plus4, e.pc + 4);
                end
            end
            prev_req = bus.imem_req;
            prev_iv = ir_valid;
        end
    end

    initial begin
        logic [31:0] instr;
        bus.imem_valid = 0;
        bus.imem_rdata = 0;
        do_reset;
        do_fetch(32'h0800_0005, 3, 1, 0);
        do_adv(2'b10, 32'h0000_0040, 0);
        do_fetch(32'h1000_FFFE, 1, 1, 1);
        do_adv(2'b01, 32'h0, 1);
        chk("branch_pc", pc, 32'h0000_003C);
        do_fetch(32'h0, 0, 1, 0);
        do_adv(2'b10, 32'hF000_0010, 0);
        do_fetch(32'h0800_0100, 2, 1, 0);
        do_adv(2'b11, 32'h0, 0);
        chk("j_pc", pc, 32'hF000_0400);
        do_fetch(32'h0, 0, 1, 0);
        do_adv(2'b10, 32'h0000_0088, 0);
        chk("jr_pc", pc, 32'h0000_0088);
        for (int n = 0; n < 40; n++) begin
            instr = $urandom;
            if (instr[31:26] == HALT_OP) instr = instr ^ 32'h0400_0000;
            do_fetch(instr, int'($urandom_range(0, 4)), $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)));
            do_adv(2'($urandom_range(0, 3)), $urandom, int'($urandom_range(0, 2)));
        end
        tick;
        tick;
        rst = 1;
        bus.imem_valid = 1;
        bus.imem_rdata = 32'hDEAD_BEEF;
        ir_wre = 1;
        ext_sel = 1;
        m_pc = RESET_PC;
        m_ir = 0;
        m_cnt = 0;
        addr_q.push_back(RESET_PC);
        tick;
        rst = 0;
        bus.imem_valid = 0;
        chk("mid_rst_ir_valid", 32'(ir_valid), 0);
        chk("mid_rst_pc", pc, RESET_PC);
        chk("mid_rst_op", 32'(op), 0);
        chk("mid_rst_imm", ext_imm, 0);
        chk("mid_rst_req", 32'(bus.imem_req), 1);
`ifdef FETCH_RETIRE_CNT_EN
        chk("mid_rst_cnt", retire_cnt, 0);
`endif
        do_fetch(32'h2000_1234, 1, 1, 0);
        do_adv(2'b00, 32'h0, 0);
        do_fetch(32'hFC00_0000, 2, 1, 0);
        pc_wre = 1;
        tick;
        chk("halted", 32'(halted), 1);
        chk("halt_ir_valid", 32'(ir_valid), 1);
        chk("halt_req", 32'(bus.imem_req), 0);
        for (int i = 0; i < 5; i++) begin
            pc_wre = 1'($urandom_range(0, 1));
            pc_src = 2'($urandom_range(0, 3));
            rs_data = $urandom;
            tick;
            chk("halt_pc", pc, m_pc);
            chk("halt_req", 32'(bus.imem_req), 0);
            chk("halted", 32'(halted), 1);
`ifdef FETCH_RETIRE_CNT_EN
            chk("halt_cnt", retire_cnt, m_cnt);
`endif
        end
        pc_wre = 0;
        tick;
        tick;
        chk("exp_q_empty", exp_q.size(), 0);
        chk("addr_q_empty", addr_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage of the multi-cycle CPU, directly upstream of the control unit.
- Owns the PC and the instruction register (IR).
- Computes the next PC from PCSrc / PCWre and fetches instructions from a variable-latency instruction memory.
- Splits the latched instruction into the op / register / immediate fields consumed by the control unit and the datapath.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- HALT_OP, 6'b111111, opcode that freezes fetch.

Ports:
- clk  in  1  system clock; every register updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- pc_wre  in  1  PCWre from the control unit; requests a PC update.
- ir_wre  in  1  IRWre from the control unit; enables IR latch on fetch return.
- pc_src  in  2  next-PC select: 00 PC+4, 01 branch, 10 jr, 11 j/jal.
- ext_sel  in  1  ExlSel: 0 zero-extend imm16, 1 sign-extend imm16.
- rs_data  in  32  register-file rs value, used as the jr target.
- imem_addr  out  32  fetch address (word aligned).
- imem_req  out  1  fetch request, held until accepted.
- imem_rdata  in  32  returned instruction.
- imem_valid  in  1  one-cycle pulse; imem_rdata is valid this cycle.
- pc  out  32  current PC.
- pc_plus4  out  32  PC+4, for the jal link write.
- op  out  6  IR[31:26].
- rs  out  5  IR[25:21].
- rt  out  5  IR[20:16].
- rd  out  5  IR[15:11].
- sa  out  5  IR[10:6].
- ext_imm  out  32  extended IR[15:0].
- ir_valid  out  1  IR holds a fetched instruction; control unit may advance.
- halted  out  1  HALT_OP has been latched.

Behaviour:
- State machine with three states:
  - FETCH: imem_req=1, imem_addr=pc.
    - On imem_valid: if ir_wre, IR<=imem_rdata; go to READY.
    - On imem_valid with ir_wre=0: IR keeps its old value; still go to READY.
  - READY: ir_valid=1, imem_req=0.
    - If op==HALT_OP, go to HALTED the next cycle.
    - Else, on pc_wre: pc<=next_pc; ir_valid drops next cycle; go to FETCH.
  - HALTED: halted=1, ir_valid=1, imem_req=0. pc_wre is ignored. Only rst exits.
- Next-PC computation (all 32-bit, modulo 2^32, wrap-around is silent):
  - 00: pc+4.
  - 01: pc+4+(ext_imm<<2).
  - 10: rs_data.
  - 11: {pc_plus4[31:28], IR[25:0], 2'b00}.
- next_pc[1:0] is forced to 00.
- pc_wre outside READY (FETCH or HALTED) is ignored; the PC is unchanged.
- Fetch latency is unbounded. imem_req stays high and imem_addr stays stable until imem_valid.
- imem_valid outside FETCH is ignored.
- ext_imm: ext_sel=1 gives {{16{IR[15]}}, IR[15:0]}; ext_sel=0 gives {16'b0, IR[15:0]}. Purely combinational from IR.
- pc_plus4 = pc+4, combinational.
- Reset (synchronous, including during a pending fetch):
  - pc<=RESET_PC, IR<=0, state<=FETCH.
  - halted=0, ir_valid=0.
  - imem_req=1 from the first cycle after reset release. It is also 1 during reset, with imem_addr=RESET_PC.
  - An outstanding imem_valid arriving in the reset cycle is discarded.
- Simultaneous imem_valid and pc_wre in FETCH: the IR latch wins; pc_wre is ignored.
- All field outputs are driven from the IR register only, never directly from imem_rdata.

Optional Feature:
- Macro: FETCH_RETIRE_CNT_EN.
- When defined:
  - Extra port retire_cnt  out  32.
  - Increments by 1 on each accepted pc_wre in READY.
  - Resets to 0 on rst; wraps at 2^32; holds in HALTED.
- When undefined: the port and the counter are absent; all other behaviour is identical.

Test Plan:
- Reset, then memory returns 32'h0800_0005 after 3 wait cycles with ir_wre=1:
  - imem_addr=0 for all 4 fetch cycles, imem_req=1.
  - Then ir_valid=1, op=6'b000010, ext_imm=32'h0000_0005.
- IR imm16=16'hFFFE, ext_sel=1, pc_src=01, pc=32'h40, pulse pc_wre -> pc=32'h3C, new fetch at 32'h3C.
- pc=32'hF000_0010, IR[25:0]=26'h0000_0100, pc_src=11, pc_wre -> pc=32'hF000_0400; pc_src=10 with rs_data=32'h88 -> pc=32'h88.
- Fetch returns 32'hFC00_0000 -> HALTED next cycle, halted=1; later pc_wre pulses leave pc unchanged and keep imem_req=0.
- rst asserted in the middle of a FETCH wait, with imem_valid arriving in the same cycle:
  - IR stays 0, pc=RESET_PC, ir_valid=0.
  - A fresh request is issued.
- pc_wre pulsed during FETCH, and simultaneously with imem_valid -> pc unchanged; IR latched; with FETCH_RETIRE_CNT_EN defined, retire_cnt unchanged.
